// File: rtl/instr_queue.sv
// instr_queue: circular instruction queue between fetch and decode with almost-full throttle.
// Optional same-cycle bypass of an empty queue when INSTR_QUEUE_BYPASS_EN is defined.
// Ports:
//   CLK            rising-edge clock
//   RESET          synchronous active-low reset
//   FREEZE         hold all state
//   FLUSH          discard contents (has priority over FREEZE)
//   enq_valid      fetch presents Instr_in/PC_in
//   deq_ready      decode consumes the head
//   out_valid      head valid; Instr_out/PC_out/is_branch_out zero when low
//   no_new_fetch   count >= AFULL_LEVEL
//   count          current occupancy
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FREEZE,
  input  logic                     FLUSH,
  input  logic                     enq_valid,
  input  logic [31:0]              Instr_in,
  input  logic [31:0]              PC_in,
  input  logic                     deq_ready,
  output logic                     out_valid,
  output logic [31:0]              Instr_out,
  output logic [31:0]              PC_out,
  output logic                     is_branch_out,
  output logic                     no_new_fetch,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic live, byp, enq_fire, deq_fire, wr, rd;
  logic [5:0] op, funct;
  always_comb begin
    live = !FREEZE && !FLUSH;
`ifdef INSTR_QUEUE_BYPASS_EN
    byp = live && enq_valid && (count == '0);
`else
    byp = 1'b0;
`endif
    out_valid = (count != '0) || byp;
    enq_fire = live && enq_valid && (count < CW'(DEPTH));
    deq_fire = live && out_valid && deq_ready;
    // a bypassed word consumed the same cycle never touches storage
    wr = enq_fire && !(byp && deq_ready);
    rd = deq_fire && !byp;
    Instr_out = byp ? Instr_in : (count != '0) ? mem_instr[rptr] : '0;
    PC_out = byp ? PC_in : (count != '0) ? mem_pc[rptr] : '0;
    op = Instr_out[31:26];
    funct = Instr_out[5:0];
    is_branch_out = (op != 6'd0 && op <= 6'd7) || (op == 6'd0 && (funct == 6'd8 || funct == 6'd9));
    no_new_fetch = count >= CW'(AFULL_LEVEL);
  end
  always_ff @(posedge CLK) begin
    if (!RESET || FLUSH) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (!FREEZE) begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET && wr) begin
      mem_instr[wptr] <= Instr_in;
      mem_pc[wptr] <= PC_in;
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: randomized and directed scoreboard bench for instr_queue against a queue model.
module tb_instr_queue;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic CLK = 1'b0, RESET = 1'b0, FREEZE = 1'b0, FLUSH = 1'b0, enq_valid = 1'b0, deq_ready = 1'b0;
  logic [31:0] Instr_in = '0, PC_in = '0;
  logic out_valid, is_branch_out, no_new_fetch;
  logic [31:0] Instr_out, PC_out;
  logic [2:0] count;
  int checks = 0, errors = 0;
  bit armed = 1'b0;
  logic [63:0] mq [$];

  instr_queue #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH),
    .enq_valid(enq_valid), .Instr_in(Instr_in), .PC_in(PC_in), .deq_ready(deq_ready),
    .out_valid(out_valid), .Instr_out(Instr_out), .PC_out(PC_out),
    .is_branch_out(is_branch_out), .no_new_fetch(no_new_fetch), .count(count)
  );

  always #5 CLK = ~CLK;

  function automatic bit branch_of(input logic [31:0] i);
    int op = int'(i[31:26]);
    int f = int'(i[5:0]);
    return (op >= 1 && op <= 7) || (op == 0 && (f == 8 || f == 9));
  endfunction

  function void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // one cycle of stimulus; the model advances at the same edge as the DUT
  task automatic cyc(input bit rn, input bit fr, input bit fl, input bit ev, input bit dr,
                     input logic [31:0] ins, input logic [31:0] pc);
    bit bp, dq, eq;
    RESET = rn; FREEZE = fr; FLUSH = fl; enq_valid = ev; deq_ready = dr; Instr_in = ins; PC_in = pc;
    @(posedge CLK);
    if (!rn || fl) mq.delete();
    else if (!fr) begin
      bp = BYP && mq.size() == 0 && ev;
      dq = dr && (mq.size() != 0 || bp);
      eq = ev && mq.size() < DEPTH;
      if (!(bp && dr)) begin
        if (dq) void'(mq.pop_front());
        if (eq) mq.push_back({ins, pc});
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // monitor: compares the presented head and status against the model mid-cycle
  always @(negedge CLK) begin
    logic [63:0] e;
    bit v, bp;
    if (armed) begin
      bp = BYP && mq.size() == 0 && enq_valid && !FLUSH && !FREEZE;
      v = mq.size() != 0 || bp;
      e = bp ? {Instr_in, PC_in} : (mq.size() != 0) ? mq[0] : 64'h0;
      chk("out_valid", 32'(out_valid), 32'(v));
      chk("instr_out", Instr_out, e[63:32]);
      chk("pc_out", PC_out, e[31:0]);
      chk("is_branch", 32'(is_branch_out), 32'(branch_of(e[63:32])));
      chk("count", 32'(count), 32'(mq.size()));
      chk("no_new_fetch", 32'(no_new_fetch), 32'(mq.size() >= AFULL));
    end
  end

  initial begin
    logic [31:0] ins;
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    armed = 1'b1;
    cyc(0, 1, 1, 1, 1, 32'hDEAD, 32'hBEEF);
    cyc(1, 0, 0, 1, 0, 32'h8C220004, 32'h100);
    idle(2);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0, 32'h1000 + i, 32'h200 + 4 * i);
    cyc(1, 0, 0, 1, 1, 32'h2000, 32'h300);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 1, 32'h3000 + i, 32'h400 + 4 * i);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 0, 1, 0, 32'h10220003, 32'h500);
    cyc(1, 0, 0, 1, 0, 32'h03E00008, 32'h504);
    cyc(1, 0, 0, 1, 0, 32'h00000000, 32'h508);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, 32'h4000 + i, 32'h600 + 4 * i);
    cyc(1, 1, 0, 1, 1, 32'h5000, 32'h700);
    cyc(1, 1, 1, 1, 0, 32'h5001, 32'h704);
    idle(1);
    cyc(1, 0, 0, 1, 1, 32'h24010001, 32'h800);
    idle(2);
    for (int i = 0; i < 800; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) ins[31:26] = 6'($urandom_range(0, 8));
      if ($urandom_range(0, 2) == 0) ins[5:0] = 6'($urandom_range(7, 10));
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ins, $urandom);
    end
    idle(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
